img_bram_responder: RTL
=======================

# img_bram_responder

- Memory-side responder for the image read/write address protocol used by the blur and pyramid stages.
- Two phases: first loads a full frame from an incoming pixel stream, then serves pixel reads and accepts pixel writes with a fixed 2-cycle read latency.
- Sits between the camera/UART frame loader and any stage that issues `addr + addr_valid` reads and `addr + valid + pixel` writes.

## Interface
- `BIT_DEPTH`, default 8: pixel width.
- `WIDTH`, default 64: image columns.
- `HEIGHT`, default 64: image rows.
- Derived: `NPIX = WIDTH*HEIGHT`, `ADDR_W = $clog2(NPIX)`.

Ports:
- `clk_in`  in  1  sole clock. Everything is posedge.
- `rst_in`  in  1  **asynchronous, active-high** reset.
- `start_load_in`  in  1  one-cycle pulse. Begins a frame load.
- `load_pixel_in`  in  BIT_DEPTH  stream pixel, raster order.
- `load_valid_in`  in  1  stream beat valid.
- `load_ready_out`  out  1  high while accepting beats.
- `load_done_out`  out  1  one-cycle pulse after the last beat.
- `serving_out`  out  1  high in SERVE.
- `rd_addr_in`  in  ADDR_W  read address.
- `rd_addr_valid_in`  in  1  read request, one per cycle max.
- `rd_pixel_out`  out  BIT_DEPTH  read data.
- `rd_pixel_valid_out`  out  1  read data valid, one-cycle pulse.
- `rd_err_out`  out  1  one-cycle pulse: request rejected.
- `wr_addr_in`  in  ADDR_W  write address.
- `wr_valid_in`  in  1  write strobe.
- `wr_pixel_in`  in  BIT_DEPTH  write data.

## Operation
- States:
  - EMPTY (reset) → LOAD on `start_load_in`.
  - LOAD → SERVE when beat `NPIX-1` is accepted.
  - SERVE → LOAD on `start_load_in`.
- `start_load_in` while in LOAD restarts the load at address 0.
- LOAD:
  - `load_ready_out = 1`.
  - A beat is accepted when `load_valid_in && load_ready_out`. It writes memory[`load_cnt`], then `load_cnt` increments.
  - On the final beat: `load_cnt` returns to 0, `load_ready_out` drops the next cycle, `load_done_out` pulses the next cycle, and the state becomes SERVE.
- SERVE:
  - A read request pipelines through 2 register stages that carry the address-valid flag and the range flag.
  - A write stores `wr_pixel_in` at `wr_addr_in`.
- Out-of-range addresses (`addr >= NPIX`):
  - A write is dropped.
  - A read returns `rd_pixel_out = 0` with `rd_pixel_valid_out = 1`, and `rd_err_out` pulses in the same cycle.
- Read while not in SERVE: no memory access. `rd_err_out` pulses 2 cycles later; `rd_pixel_valid_out` stays 0.
- Writes while not in SERVE are ignored.
- Read and write to the same address in the same cycle: the read returns the old data (read-first). The new data is visible to reads issued on any later cycle.
- `rd_pixel_out` holds its last value until the next valid read.
- Reset, including mid-load:
  - State → EMPTY, `load_cnt` → 0, read pipeline flushed. No `rd_pixel_valid_out` emerges from requests that were in flight.
  - Memory contents are not cleared.

## Timing
- Reset values: `load_ready_out=0`, `load_done_out=0`, `serving_out=0`, `rd_pixel_out=0`, `rd_pixel_valid_out=0`, `rd_err_out=0`.
- Read latency: request at edge N → data and valid visible after edge N+2. Fully pipelined: one request per cycle sustains one result per cycle.
- `serving_out` rises in the same cycle as `load_done_out`.
- A read issued in the cycle `load_done_out` is high is served.
- `start_load_in` in SERVE:
  - `serving_out` and `load_ready_out` switch on the next edge.
  - Reads already in flight still complete with their data.
- Load throughput: one beat per cycle. No bubbles are required when `load_valid_in` stays high.

## Structure
- Package `img_pkg`:
  - `NPIX` and `ADDR_W` helper functions.
  - State enum `bram_state_t {EMPTY, LOAD, SERVE}`.
  - A `pixel_t` typedef parameterised through the function or macro, shared with the blur stage.
- Sub-module `img_ram`:
  - Simple dual-port RAM, synchronous read with a registered output (2-cycle total).
  - Port A: write, muxed between load and SERVE writes.
  - Port B: read.
  - Read-first behaviour.
- The FSM, load counter, and read-flag pipeline live in the top.

## Test plan
All tests use `WIDTH=4`, `HEIGHT=4` (NPIX=16).
1. **Reset.** Assert `rst_in` asynchronously mid-cycle → all outputs 0 immediately. Reads at addresses 0..15 produce no `rd_pixel_valid_out`.
2. **Load.** Pulse `start_load`, then stream 16 beats of `0x10+i` with valid high → `load_ready_out` high for exactly 16 cycles. `load_done_out` pulses once one cycle after beat 15. `serving_out`=1.
3. **Read path.** Back-to-back reads of addresses 0,5,15 → `rd_pixel_out` = 0x10, 0x15, 0x1F on three consecutive cycles, starting 2 cycles after the first request.
4. **Read-first collision, then readback.** In one cycle, write 0xAA to address 3 and read address 3 → result 0x13. The next read of 3 → 0xAA.
5. **Errors.** Read address 16 is not applicable (ADDR_W=4, so 16 is unreachable); use a `WIDTH=3`, `HEIGHT=3` instance instead:
   - Read address 9 → `rd_pixel_out=0`, valid=1, `rd_err_out`=1.
   - Read in EMPTY → `rd_err_out`=1 and valid=0.
6. **Restart and reset mid-load.**
   - Pulse `start_load` in SERVE, load 7 beats, assert reset → state EMPTY and `load_ready_out`=0.
   - Reload fully → reads return the new frame.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image types and geometry helpers for the blur/pyramid pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package img_pkg;

  // Default pixel width used by stages that do not override BIT_DEPTH.
  localparam int DEFAULT_BIT_DEPTH = 8;

  typedef logic [DEFAULT_BIT_DEPTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } bram_state_t;

  // Pixels in a frame.
  function automatic int npix(input int width, input int height);
    return width * height;
  endfunction

  // Address width for a frame; a 1-pixel frame still needs one address bit.
  function automatic int addr_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction

endpackage

// File: rtl/img_ram.sv
// Simple dual-port frame RAM: port A writes, port B reads, read-first on collision.
// Latency: 2 cycles read (array read register, then output register).
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports:
//   clk_in, rst_in             clock, async active-high reset (output register only)
//   wr_en, wr_addr, wr_data    port A write
//   rd_en, rd_addr             port B read (stage 1)
//   out_en, out_zero           stage-2 output load; out_zero forces the loaded value to 0
//   rd_data                    registered read data, holds between loads
module img_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          out_en,
  input  logic          out_zero,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;

  // Array and its read register carry no reset so they map onto block RAM.
  // Both updates are non-blocking, so a same-cycle read sees the old word.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_data <= '0;
    end else if (out_en) begin
      rd_data <= out_zero ? '0 : rd_q;
    end
  end

endmodule

// File: rtl/img_bram_responder.sv
// Frame memory responder: loads a raster frame from a stream, then serves reads/writes.
// Latency: reads 2 cycles, fully pipelined; load accepts one beat per cycle.
// Backpressure: load_ready_out high only in LOAD; reads/writes are never stalled.
//
// Ports:
//   clk_in, rst_in                                  clock, async active-high reset
//   start_load_in                                   pulse: (re)start frame load at address 0
//   load_pixel_in, load_valid_in, load_ready_out    load stream handshake
//   load_done_out                                   pulse after the last beat
//   serving_out                                     high while serving reads/writes
//   rd_addr_in, rd_addr_valid_in                    read request
//   rd_pixel_out, rd_pixel_valid_out, rd_err_out    read response
//   wr_addr_in, wr_valid_in, wr_pixel_in            write request
module img_bram_responder
  import img_pkg::*;
#(
  parameter  int BIT_DEPTH = 8,
  parameter  int WIDTH     = 64,
  parameter  int HEIGHT    = 64,
  localparam int NPIX      = npix(WIDTH, HEIGHT),
  localparam int ADDR_W    = addr_w(WIDTH, HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_load_in,
  input  logic [BIT_DEPTH-1:0] load_pixel_in,
  input  logic                 load_valid_in,
  output logic                 load_ready_out,
  output logic                 load_done_out,
  output logic                 serving_out,
  input  logic [ADDR_W-1:0]    rd_addr_in,
  input  logic                 rd_addr_valid_in,
  output logic [BIT_DEPTH-1:0] rd_pixel_out,
  output logic                 rd_pixel_valid_out,
  output logic                 rd_err_out,
  input  logic [ADDR_W-1:0]    wr_addr_in,
  input  logic                 wr_valid_in,
  input  logic [BIT_DEPTH-1:0] wr_pixel_in
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_SERVE = SERVE;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  logic [1:0]          state;
  logic [ADDR_W-1:0]   load_cnt;
  logic                in_load;
  logic                in_serve;
  logic                beat;
  logic                last_beat;
  logic                rd_in_range;
  logic                wr_in_range;
  logic                ram_wr_en;
  logic [ADDR_W-1:0]   ram_wr_addr;
  logic [BIT_DEPTH-1:0] ram_wr_data;
  logic                ram_rd_en;

  // Read-flag pipeline, stage 1 (aligned with the RAM read register).
  logic                rd_vld_q;
  logic                rd_srv_q;
  logic                rd_rng_q;

  assign in_load        = (state == ST_LOAD);
  assign in_serve       = (state == ST_SERVE);
  assign load_ready_out = in_load;
  assign serving_out    = in_serve;

  // A restart pulse wins over a coincident beat: that beat is discarded and
  // the frame starts again from address 0 on the next cycle.
  assign beat      = in_load && load_valid_in && !start_load_in;
  assign last_beat = beat && (load_cnt == LAST_ADDR);

  // NPIX need not be a power of two, so compare in a wide domain.
  assign rd_in_range = (32'(rd_addr_in) < 32'(NPIX));
  assign wr_in_range = (32'(wr_addr_in) < 32'(NPIX));

  // Port A is shared: the loader owns it in LOAD, external writes in SERVE.
  assign ram_wr_en   = beat || (in_serve && wr_valid_in && wr_in_range);
  assign ram_wr_addr = in_load ? load_cnt : wr_addr_in;
  assign ram_wr_data = in_load ? load_pixel_in : wr_pixel_in;

  // Only touch the array for requests that will return real data.
  assign ram_rd_en = rd_addr_valid_in && in_serve && rd_in_range;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_EMPTY;
      load_cnt      <= '0;
      load_done_out <= 1'b0;
    end else begin
      load_done_out <= last_beat;
      if (start_load_in) begin
        state    <= ST_LOAD;
        load_cnt <= '0;
      end else if (last_beat) begin
        state    <= ST_SERVE;
        load_cnt <= '0;
      end else if (beat) begin
        load_cnt <= load_cnt + ADDR_W'(1);
      end
    end
  end

  // Serve/range flags are captured with the request, so reads in flight when
  // a new load starts still complete with their data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_vld_q           <= 1'b0;
      rd_srv_q           <= 1'b0;
      rd_rng_q           <= 1'b0;
      rd_pixel_valid_out <= 1'b0;
      rd_err_out         <= 1'b0;
    end else begin
      rd_vld_q           <= rd_addr_valid_in;
      rd_srv_q           <= in_serve;
      rd_rng_q           <= rd_in_range;
      rd_pixel_valid_out <= rd_vld_q && rd_srv_q;
      rd_err_out         <= rd_vld_q && (!rd_srv_q || !rd_rng_q);
    end
  end

  img_ram #(
    .DEPTH (NPIX),
    .AW    (ADDR_W),
    .DW    (BIT_DEPTH)
  ) u_ram (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr_en    (ram_wr_en),
    .wr_addr  (ram_wr_addr),
    .wr_data  (ram_wr_data),
    .rd_en    (ram_rd_en),
    .rd_addr  (rd_addr_in),
    .out_en   (rd_vld_q && rd_srv_q),
    .out_zero (!rd_rng_q),
    .rd_data  (rd_pixel_out)
  );

endmodule
